// File: rtl/ramio_arbiter.sv
// ramio_arbiter: two-requester round-robin arbiter in front of a single RAM/IO port.
// A granted requester is muxed straight onto the shared port until its access
// finishes; every access is followed by one idle bubble cycle before the next grant.
module ramio_arbiter #(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       p0_enable,
  input  logic [1:0]                 p0_write_type,
  input  logic [2:0]                 p0_read_type,
  input  logic [AddressBitWidth-1:0] p0_address,
  input  logic [DataBitWidth-1:0]    p0_data_in,
  output logic [DataBitWidth-1:0]    p0_data_out,
  output logic                       p0_data_out_ready,
  output logic                       p0_busy,
  input  logic                       p1_enable,
  input  logic [1:0]                 p1_write_type,
  input  logic [2:0]                 p1_read_type,
  input  logic [AddressBitWidth-1:0] p1_address,
  input  logic [DataBitWidth-1:0]    p1_data_in,
  output logic [DataBitWidth-1:0]    p1_data_out,
  output logic                       p1_data_out_ready,
  output logic                       p1_busy,
  output logic                       rm_enable,
  output logic [1:0]                 rm_write_type,
  output logic [2:0]                 rm_read_type,
  output logic [AddressBitWidth-1:0] rm_address,
  output logic [DataBitWidth-1:0]    rm_data_in,
  input  logic [DataBitWidth-1:0]    rm_data_out,
  input  logic                       rm_data_out_ready,
  input  logic                       rm_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   p0_done, p1_done;

  // An access ends once the port is free; reads additionally need returned data.
  // A dropped enable or an empty (no read, no write) request ends on port free alone.
  function automatic logic xfer_done(input logic en, input logic [1:0] wt,
                                     input logic [2:0] rt, input logic busy,
                                     input logic rdy);
    return !busy && (!en || (wt != 2'b00) || (rt == 3'b000) || rdy);
  endfunction

  assign p0_done = xfer_done(p0_enable, p0_write_type, p0_read_type, rm_busy, rm_data_out_ready);
  assign p1_done = xfer_done(p1_enable, p1_write_type, p1_read_type, rm_busy, rm_data_out_ready);

  // Ownership state and round-robin memory; reset favours requester 0 on first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Grant decision, completion detection and port muxing.
  always_comb begin
    state_nxt         = state;
    last_grant_nxt    = last_grant;
    rm_enable         = 1'b0;
    rm_write_type     = '0;
    rm_read_type      = '0;
    rm_address        = '0;
    rm_data_in        = '0;
    p0_data_out       = '0;
    p0_data_out_ready = 1'b0;
    p0_busy           = p0_enable;
    p1_data_out       = '0;
    p1_data_out_ready = 1'b0;
    p1_busy           = p1_enable;
    case (state)
      IDLE: begin
        if (p0_enable && p1_enable) begin
          state_nxt      = last_grant ? OWN0 : OWN1;
          last_grant_nxt = ~last_grant;
        end else if (p0_enable) begin
          state_nxt      = OWN0;
          last_grant_nxt = 1'b0;
        end else if (p1_enable) begin
          state_nxt      = OWN1;
          last_grant_nxt = 1'b1;
        end
      end
      OWN0: begin
        rm_enable         = p0_enable;
        rm_write_type     = p0_write_type;
        rm_read_type      = p0_read_type;
        rm_address        = p0_address;
        rm_data_in        = p0_data_in;
        p0_data_out       = rm_data_out;
        p0_data_out_ready = rm_data_out_ready;
        p0_busy           = !p0_done;
        if (p0_done) state_nxt = IDLE;
      end
      OWN1: begin
        rm_enable         = p1_enable;
        rm_write_type     = p1_write_type;
        rm_read_type      = p1_read_type;
        rm_address        = p1_address;
        rm_data_in        = p1_data_in;
        p1_data_out       = rm_data_out;
        p1_data_out_ready = rm_data_out_ready;
        p1_busy           = !p1_done;
        if (p1_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter: random two-requester traffic against a latency-randomised RAM
// responder with a read-data scoreboard and a round-robin grant-order model,
// followed by directed scenarios for the corner cases.
module tb_ramio_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NTX = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en   [2];
  logic [1:0]    wt   [2];
  logic [2:0]    rt   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];

  logic [DW-1:0] p0_data_out, p1_data_out;
  logic          p0_data_out_ready, p1_data_out_ready, p0_busy, p1_busy;
  logic          rm_enable;
  logic [1:0]    rm_write_type;
  logic [2:0]    rm_read_type;
  logic [AW-1:0] rm_address;
  logic [DW-1:0] rm_data_in, rm_data_out;
  logic          rm_data_out_ready, rm_busy;

  // RAM responder: automatic random latency, or fully driven by directed tests
  logic          ram_auto = 1'b1;
  logic          d_busy = 1'b0, d_ready = 1'b0;
  logic [DW-1:0] d_data = '0;
  int unsigned   lat_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit rr_on = 0, sb_on = 0;

  ramio_arbiter #(.AddressBitWidth(AW), .DataBitWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_enable(en[0]), .p0_write_type(wt[0]), .p0_read_type(rt[0]),
    .p0_address(addr[0]), .p0_data_in(din[0]),
    .p0_data_out(p0_data_out), .p0_data_out_ready(p0_data_out_ready), .p0_busy(p0_busy),
    .p1_enable(en[1]), .p1_write_type(wt[1]), .p1_read_type(rt[1]),
    .p1_address(addr[1]), .p1_data_in(din[1]),
    .p1_data_out(p1_data_out), .p1_data_out_ready(p1_data_out_ready), .p1_busy(p1_busy),
    .rm_enable(rm_enable), .rm_write_type(rm_write_type), .rm_read_type(rm_read_type),
    .rm_address(rm_address), .rm_data_in(rm_data_in),
    .rm_data_out(rm_data_out), .rm_data_out_ready(rm_data_out_ready), .rm_busy(rm_busy)
  );

  // Contents the memory returns for a read of address a
  function automatic logic [31:0] ref_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  function automatic logic get_busy(input int n);
    return (n == 0) ? p0_busy : p1_busy;
  endfunction

  // Responder latency counter: new random latency at every access boundary
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= $urandom_range(0, 3);
    else if (!rm_enable || lat_cnt == 0) lat_cnt <= $urandom_range(0, 3);
    else lat_cnt <= lat_cnt - 1;
  end

  assign rm_busy           = ram_auto ? (rm_enable && lat_cnt != 0) : d_busy;
  assign rm_data_out_ready = ram_auto ? (rm_enable && lat_cnt == 0 && rm_read_type != 3'b000) : d_ready;
  assign rm_data_out       = ram_auto ? (rm_data_out_ready ? ref_data(rm_address) : 32'hFFFF_FFFF) : d_data;

  // Scoreboard monitor: every read-data strobe must match the oldest outstanding read
  initial forever begin
    @(negedge clk);
    if (sb_on) begin
      if (p0_data_out_ready) begin
        if (exp_q0.size() == 0) chk("p0_unexpected_ready", 1, 0);
        else chk("p0_rdata", p0_data_out, exp_q0.pop_front());
      end
      if (p1_data_out_ready) begin
        if (exp_q1.size() == 0) chk("p1_unexpected_ready", 1, 0);
        else chk("p1_rdata", p1_data_out, exp_q1.pop_front());
      end
    end
  end

  // Grant-order model: a new access starts after an idle cycle; with both pending
  // there, the requester not served last wins, otherwise the only pending one.
  initial begin
    logic       prev_en, who, expw, last_served;
    logic [1:0] prev_pend;
    prev_en = 0; prev_pend = 0; last_served = 1;
    forever begin
      @(negedge clk);
      if (rr_on && rm_enable && !prev_en) begin
        who  = rm_address[16];
        expw = (prev_pend == 2'b11) ? ~last_served : prev_pend[1];
        chk("grant_order", {prev_pend != 2'b00, who}, {1'b1, expw});
        last_served = who;
      end
      prev_en   = rm_enable;
      prev_pend = {en[1], en[0]};
    end
  end

  // One random requester: gap, issue, hold until busy drops, verify the port view
  task automatic requester(input int n, input int ntx);
    logic [31:0] a, d;
    logic [1:0]  w;
    logic [2:0]  r;
    int          gap;
    bit          done;
    for (int k = 0; k < ntx; k++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        en[n] = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      a = {15'd0, 1'(n), 16'($urandom)};
      d = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    begin w = 2'($urandom_range(1, 3)); r = 3'b000; end
        2, 3:    begin w = 2'b00; r = {1'($urandom), 2'($urandom_range(1, 3))}; end
        default: begin w = 2'b00; r = 3'b000; end
      endcase
      en[n] = 1'b1; wt[n] = w; rt[n] = r; addr[n] = a; din[n] = d;
      if (r != 3'b000) begin
        if (n == 0) exp_q0.push_back(ref_data(a));
        else        exp_q1.push_back(ref_data(a));
      end
      done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
        @(negedge clk);
        if (!get_busy(n)) done = 1;
      end
      chk($sformatf("p%0d_completes", n), done, 1);
      if (done) begin
        chk($sformatf("p%0d_rm_enable", n), rm_enable, 1);
        chk($sformatf("p%0d_rm_address", n), rm_address, a);
        chk($sformatf("p%0d_rm_type", n), {rm_write_type, rm_read_type}, {w, r});
        if (w != 2'b00) chk($sformatf("p%0d_rm_data_in", n), rm_data_in, d);
      end
      @(posedge clk); #1;
    end
    en[n] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic [1:0] w, input logic [2:0] r,
                         input logic [31:0] a, input logic [31:0] d);
    en[n] = 1'b1; wt[n] = w; rt[n] = r; addr[n] = a; din[n] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int busy_low;
    for (int i = 0; i < 2; i++) begin
      en[i] = 0; wt[i] = 0; rt[i] = 0; addr[i] = 0; din[i] = 0;
    end

    // ---- reset state ----
    en[0] = 1'b1; wt[0] = 2'b11; addr[0] = 32'h44;
    #12;
    chk("rst_rm_enable", rm_enable, 0);
    chk("rst_rm_fields", {rm_write_type, rm_read_type, rm_address, rm_data_in}, 0);
    chk("rst_busy_follows_en", {p1_busy, p0_busy}, 2'b01);
    chk("rst_ready", {p1_data_out_ready, p0_data_out_ready}, 0);
    chk("rst_data_out", {p1_data_out, p0_data_out}, 0);
    en[0] = 1'b0; en[1] = 1'b1; #1;
    chk("rst_busy_follows_en2", {p1_busy, p0_busy}, 2'b10);
    en[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- random traffic ----
    rr_on = 1; sb_on = 1;
    fork
      requester(0, NTX);
      requester(1, NTX);
    join
    tick(); tick();
    chk("sb0_drained", exp_q0.size(), 0);
    chk("sb1_drained", exp_q1.size(), 0);
    rr_on = 0; sb_on = 0; ram_auto = 1'b0;

    // ---- p0 word read with three busy cycles ----
    tick();
    d_busy = 1; d_ready = 0; d_data = 0;
    set_req(0, 2'b00, 3'b011, 32'h100, 0);
    nedge();
    chk("rd_idle_no_req", rm_enable, 0);
    busy_low = 0;
    tick(); nedge();
    chk("rd_rm_enable", rm_enable, 1);
    chk("rd_rm_address", rm_address, 32'h100);
    chk("rd_rm_read_type", rm_read_type, 3'b011);
    busy_low += int'(!p0_busy);
    tick(); nedge(); busy_low += int'(!p0_busy);
    tick(); nedge(); busy_low += int'(!p0_busy);
    tick(); d_busy = 0; d_ready = 1; d_data = 32'hDEADBEEF;
    nedge(); busy_low += int'(!p0_busy);
    chk("rd_data_out", p0_data_out, 32'hDEADBEEF);
    chk("rd_ready", p0_data_out_ready, 1);
    chk("rd_busy_low_cycles", busy_low, 1);
    tick(); en[0] = 0; d_ready = 0; d_data = 0;
    nedge();
    chk("rd_bubble_idle", rm_enable, 0);

    // ---- p1 byte write, zero wait ----
    tick();
    d_busy = 0;
    set_req(1, 2'b01, 3'b000, 32'h203, 32'h55);
    nedge();
    chk("bw_idle_busy", p1_busy, 1);
    tick(); nedge();
    chk("bw_rm_write_type", rm_write_type, 2'b01);
    chk("bw_rm_address", rm_address, 32'h203);
    chk("bw_rm_data_in", rm_data_in, 32'h55);
    chk("bw_done", p1_busy, 0);
    tick(); en[1] = 0;
    nedge();
    chk("bw_bubble", rm_enable, 0);

    // ---- p0 owns while p1 waits; stray data strobe must not reach p1 ----
    tick();
    d_busy = 1;
    set_req(0, 2'b00, 3'b011, 32'h300, 0);
    set_req(1, 2'b11, 3'b000, 32'h0001_0400, 32'hA5A5_0001);
    nedge();
    tick(); nedge();
    chk("nb_owner_p0", rm_address, 32'h300);
    chk("nb_p1_busy", p1_busy, 1);
    tick(); d_ready = 1; d_data = 32'h1234;
    nedge();
    chk("nb_p1_shielded", {p1_busy, p1_data_out_ready, p1_data_out}, {1'b1, 1'b0, 32'h0});
    chk("nb_p0_not_done", p0_busy, 1);
    tick(); d_busy = 0; d_data = 32'hCAFE_0001;
    nedge();
    chk("nb_p0_data", {p0_busy, p0_data_out}, {1'b0, 32'hCAFE_0001});
    chk("nb_p1_no_ready", p1_data_out_ready, 0);
    tick(); en[0] = 0; d_ready = 0;
    nedge();
    chk("nb_bubble", rm_enable, 0);
    tick(); nedge();
    chk("nb_p1_served", {rm_address, p1_busy}, {32'h0001_0400, 1'b0});
    tick(); en[1] = 0;

    // ---- owner drops enable while port busy ----
    tick();
    d_busy = 1;
    set_req(0, 2'b00, 3'b011, 32'h500, 0);
    nedge();
    tick(); nedge();
    chk("dr_rm_enable", rm_enable, 1);
    tick(); en[0] = 0;
    set_req(1, 2'b11, 3'b000, 32'h0001_0600, 32'h77);
    nedge();
    chk("dr_rm_enable_drops", {rm_enable, p0_data_out_ready, p1_busy}, 3'b001);
    tick(); nedge();
    chk("dr_hold_owner", rm_enable, 0);
    tick(); d_busy = 0;
    nedge();
    chk("dr_release_cycle", {rm_enable, p0_data_out_ready}, 2'b00);
    tick(); nedge();
    chk("dr_idle", {rm_enable, p1_busy}, 2'b01);
    tick(); nedge();
    chk("dr_p1_served", {rm_address, p1_busy}, {32'h0001_0600, 1'b0});
    tick(); en[1] = 0;

    // ---- reset during OWN1, then contention and round-robin order ----
    tick();
    d_busy = 1;
    set_req(1, 2'b11, 3'b000, 32'h0001_0700, 32'h88);
    nedge();
    tick(); nedge();
    chk("ar_own1", {rm_enable, rm_address}, {1'b1, 32'h0001_0700});
    #1 rst_n = 1'b0;
    #1;
    chk("ar_async_drop", {rm_enable, rm_address, p1_busy, p1_data_out_ready}, {1'b0, 32'h0, 1'b1, 1'b0});
    set_req(0, 2'b11, 3'b000, 32'h800, 32'h11);
    set_req(1, 2'b11, 3'b000, 32'h0001_0900, 32'h22);
    d_busy = 0;
    @(posedge clk); #1;
    chk("ar_in_reset", rm_enable, 0);
    rst_n = 1'b1;
    nedge();
    chk("ar_first_idle", rm_enable, 0);
    tick(); nedge();
    chk("rr_p0_first", {rm_address, p0_busy, p1_busy}, {32'h800, 1'b0, 1'b1});
    tick(); addr[0] = 32'hA00;
    nedge();
    chk("rr_bubble", rm_enable, 0);
    tick(); nedge();
    chk("rr_p1_next", {rm_address, p1_busy, p0_busy}, {32'h0001_0900, 1'b0, 1'b1});
    tick(); en[1] = 0;
    nedge();
    tick(); nedge();
    chk("rr_p0_again", {rm_address, p0_busy}, {32'hA00, 1'b0});
    tick(); en[0] = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ramio_arbiter.md
RAMIO_ARBITER -- requirements
Module: ramio_arbiter

Interface
REQ-001 Parameter AddressBitWidth, default 32, width of all address ports.
REQ-002 Parameter DataBitWidth, default 32, width of all data ports.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 pN_enable  input  1  requester N (N=0,1) has a pending access.
REQ-006 pN_write_type  input  2  b00 none, b01 byte, b10 half word, b11 word.
REQ-007 pN_read_type  input  3  b000 none; bit[2] sign-extend; [1:0] size as write_type.
REQ-008 pN_address  input  AddressBitWidth  byte address.
REQ-009 pN_data_in  input  DataBitWidth  write data.
REQ-010 pN_data_out  output  DataBitWidth  read data for requester N.
REQ-011 pN_data_out_ready  output  1  read data valid for requester N.
REQ-012 pN_busy  output  1  requester N must hold its request stable.
REQ-013 rm_enable, rm_write_type, rm_read_type, rm_address, rm_data_in  outputs  1/2/3/AddressBitWidth/DataBitWidth  shared RAM/IO port request.
REQ-014 rm_data_out  input  DataBitWidth  shared port read data.
REQ-015 rm_data_out_ready  input  1  shared port read data valid.
REQ-016 rm_busy  input  1  shared port busy.

Function
REQ-017 States IDLE, OWN0, OWN1; a register last_grant (0/1) records the most recently granted requester.
REQ-018 IDLE: all rm_* request outputs 0; both pN_busy equal pN_enable; both pN_data_out_ready 0.
REQ-019 IDLE, only pN_enable high: next state OWNN, last_grant <= N; grant latency one cycle.
REQ-020 IDLE, both enables high: grant the requester not equal to last_grant (round-robin).
REQ-021 OWNN: rm_* request outputs equal requester N inputs combinationally; pN_data_out = rm_data_out; pN_data_out_ready = rm_data_out_ready.
REQ-022 Completion in OWNN: rm_busy==0 and (pN_write_type!=0 or rm_data_out_ready==1) in the same cycle.
REQ-023 OWNN pN_busy = 0 only in the completion cycle; 1 in all other cycles.
REQ-024 On completion, next state is always IDLE (one bubble cycle); the requester must drop or change its request in that bubble.
REQ-025 Non-owner M in OWNN: pM_busy = pM_enable, pM_data_out = 0, pM_data_out_ready = 0.
REQ-026 Owner drops pN_enable in OWNN: rm_enable follows (0); state stays OWNN until rm_busy==0, then IDLE.
REQ-027 Owner enable high with write_type==0 and read_type==0: complete when rm_busy==0.
REQ-028 No data transformation: widths and sign-extension are handled downstream, arbiter is pure sequencing and muxing.
REQ-029 No request is ever issued to rm_* for a requester whose pN_enable is low.

Reset
REQ-030 While rst_n low: state IDLE, last_grant = 1 (requester 0 wins first contention).
REQ-031 While rst_n low: all rm_* request outputs 0, all pN_data_out and pN_data_out_ready 0, pN_busy = pN_enable.
REQ-032 Reset asserted mid-transaction: ownership discarded immediately; no completion reported after release.

Verification
REQ-033 p0 read word 0x100, rm_busy 3 cycles then rm_data_out_ready with 0xDEADBEEF -> p0_data_out 0xDEADBEEF, p0_busy low exactly one cycle, then IDLE.
REQ-034 Both enables high first cycle after reset -> OWN0 granted; after p0 completion and bubble, p1 granted while p0 re-requests -> p1 served before p0.
REQ-035 p1 byte write 0x55 to 0x203, rm_busy 0 -> rm_write_type b01, rm_address 0x203, rm_data_in 0x55, completion next cycle after grant.
REQ-036 p0 owns, p1 requests throughout -> p1_busy held 1, p1_data_out_ready 0 even when rm_data_out_ready pulses.
REQ-037 Owner drops enable while rm_busy high for 2 cycles -> rm_enable 0 immediately, state IDLE after rm_busy falls, no data_out_ready to owner.
REQ-038 rst_n pulsed low during OWN1 -> rm_enable 0 asynchronously, state IDLE, last_grant 1, next contention grants p0.
